// File: rtl/hazard_fwd_if.sv
// Decode-side bundle of the hazard/forwarding unit: issue info and regfile/stage
// results in, forwarded operands, selects and stall out.
interface hazard_fwd_if #(
   parameter int WIDTH = 16,
   parameter int NREG  = 16,
   parameter int DEPTH = 3
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int SW = $clog2(DEPTH + 1);

   logic                   issue_valid;
   logic [AW-1:0]          rs1;
   logic [AW-1:0]          rs2;
   logic                   rs1_used;
   logic                   rs2_used;
   logic [AW-1:0]          rd;
   logic                   rd_we;
   logic                   is_load;
   logic                   flush;
   logic [WIDTH-1:0]       rf_data1;
   logic [WIDTH-1:0]       rf_data2;
   logic [DEPTH*WIDTH-1:0] stage_data;
   logic [WIDTH-1:0]       opnd1;
   logic [WIDTH-1:0]       opnd2;
   logic [SW-1:0]          fwd_sel1;
   logic [SW-1:0]          fwd_sel2;
   logic                   stall;
   logic [15:0]            stall_count;

   modport master (
      output issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_we, is_load, flush,
      output rf_data1, rf_data2, stage_data,
      input  opnd1, opnd2, fwd_sel1, fwd_sel2, stall, stall_count
   );

   modport slave (
      input  issue_valid, rs1, rs2, rs1_used, rs2_used, rd, rd_we, is_load, flush,
      input  rf_data1, rf_data2, stage_data,
      output opnd1, opnd2, fwd_sel1, fwd_sel2, stall, stall_count
   );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Tracks in-flight register writes over DEPTH post-decode stages, forwards the
// youngest ready result into decode and stalls decode on load-use hazards.
module hazard_fwd_unit #(
   parameter int WIDTH    = 16,
   parameter int NREG     = 16,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1
) (
   input  logic           clk,
   input  logic           reset,
   hazard_fwd_if.slave    bus
);
   localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int SW = $clog2(DEPTH + 1);
   localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] rd;
      logic          we;
      logic [LW-1:0] lat;
   } entry_t;

   entry_t           pipe [DEPTH];
   logic [15:0]      stallCount;

   logic             hit1, hit2;
   logic             rdy1, rdy2;
   logic [SW-1:0]    sel1, sel2;
   logic [WIDTH-1:0] data1, data2;
   logic             stallInt;
   logic             accept;

   // Scan oldest to youngest so the lowest index match overwrites older ones.
   always_comb begin
      hit1  = 1'b0;
      hit2  = 1'b0;
      rdy1  = 1'b0;
      rdy2  = 1'b0;
      sel1  = '0;
      sel2  = '0;
      data1 = '0;
      data2 = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (pipe[k].valid && pipe[k].we && bus.rs1_used && (pipe[k].rd == bus.rs1)) begin
            hit1  = 1'b1;
            rdy1  = (k >= int'(pipe[k].lat));
            sel1  = SW'(k + 1);
            data1 = bus.stage_data[k*WIDTH +: WIDTH];
         end
         if (pipe[k].valid && pipe[k].we && bus.rs2_used && (pipe[k].rd == bus.rs2)) begin
            hit2  = 1'b1;
            rdy2  = (k >= int'(pipe[k].lat));
            sel2  = SW'(k + 1);
            data2 = bus.stage_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign stallInt = bus.issue_valid && !bus.flush && ((hit1 && !rdy1) || (hit2 && !rdy2));
   assign accept   = bus.issue_valid && !bus.flush && !stallInt;

   // An unready match falls back to the regfile view; decode is stalled anyway.
   assign bus.fwd_sel1    = (hit1 && rdy1) ? sel1 : '0;
   assign bus.fwd_sel2    = (hit2 && rdy2) ? sel2 : '0;
   assign bus.opnd1       = (hit1 && rdy1) ? data1 : bus.rf_data1;
   assign bus.opnd2       = (hit2 && rdy2) ? data2 : bus.rf_data2;
   assign bus.stall       = stallInt;
   assign bus.stall_count = stallCount;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            pipe[k] <= '0;
         end
         stallCount <= '0;
      end else begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            pipe[k] <= pipe[k-1];
         end
         if (accept) begin
            pipe[0].valid <= 1'b1;
            pipe[0].rd    <= bus.rd;
            pipe[0].we    <= bus.rd_we;
            pipe[0].lat   <= bus.is_load ? LW'(LOAD_LAT) : '0;
         end else begin
            pipe[0] <= '0;
         end
         if (stallInt && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: expected outputs are queued as each step is
// driven and popped for comparison mid-cycle; a deep instance covers saturation.
module tb_hazard_fwd_unit;
   logic clk;
   logic reset;

   hazard_fwd_if #(.WIDTH(16), .NREG(16), .DEPTH(3))  busA ();
   hazard_fwd_if #(.WIDTH(16), .NREG(16), .DEPTH(32)) busS ();

   hazard_fwd_unit #(.WIDTH(16), .NREG(16), .DEPTH(3), .LOAD_LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busA)
   );

   hazard_fwd_unit #(.WIDTH(16), .NREG(16), .DEPTH(32), .LOAD_LAT(31)) dutSat (
      .clk   (clk),
      .reset (reset),
      .bus   (busS)
   );

   typedef struct {
      string       tag;
      logic        care;
      logic [15:0] opnd1;
      logic [15:0] opnd2;
      logic [1:0]  sel1;
      logic [1:0]  sel2;
      logic        stall;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2, input logic [3:0] d,
                        input logic we, input logic ld, input logic fl);
      busA.issue_valid = iv;
      busA.rs1         = r1;
      busA.rs1_used    = u1;
      busA.rs2         = r2;
      busA.rs2_used    = u2;
      busA.rd          = d;
      busA.rd_we       = we;
      busA.is_load     = ld;
      busA.flush       = fl;
   endtask

   task automatic expectOut(input string tag, input logic care, input logic [15:0] eo1,
                            input logic [15:0] eo2, input logic [1:0] es1, input logic [1:0] es2,
                            input logic est, input logic [15:0] ecnt);
      exp_t e;
      e.tag = tag; e.care = care; e.opnd1 = eo1; e.opnd2 = eo2;
      e.sel1 = es1; e.sel2 = es2; e.stall = est; e.cnt = ecnt;
      sb.push_back(e);
   endtask

   task automatic compareHead();
      exp_t e;
      if (sb.size() == 0) begin
         cmp("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         cmp({e.tag, ".stall"}, {31'd0, busA.stall}, {31'd0, e.stall});
         cmp({e.tag, ".stall_count"}, {16'd0, busA.stall_count}, {16'd0, e.cnt});
         if (e.care) begin
            cmp({e.tag, ".fwd_sel1"}, {30'd0, busA.fwd_sel1}, {30'd0, e.sel1});
            cmp({e.tag, ".fwd_sel2"}, {30'd0, busA.fwd_sel2}, {30'd0, e.sel2});
            cmp({e.tag, ".opnd1"}, {16'd0, busA.opnd1}, {16'd0, e.opnd1});
            cmp({e.tag, ".opnd2"}, {16'd0, busA.opnd2}, {16'd0, e.opnd2});
         end
      end
   endtask

   task automatic step(input string tag, input logic iv, input logic [3:0] r1, input logic u1,
                       input logic [3:0] r2, input logic u2, input logic [3:0] d,
                       input logic we, input logic ld, input logic fl, input logic care,
                       input logic [15:0] eo1, input logic [15:0] eo2, input logic [1:0] es1,
                       input logic [1:0] es2, input logic est, input logic [15:0] ecnt);
      drive(iv, r1, u1, r2, u2, d, we, ld, fl);
      expectOut(tag, care, eo1, eo2, es1, es2, est, ecnt);
      @(negedge clk);
      compareHead();
      @(posedge clk);
      #1;
   endtask

   localparam logic [15:0] RF1 = 16'h1111;
   localparam logic [15:0] RF2 = 16'h2222;
   localparam logic [15:0] SD0 = 16'h00AA;
   localparam logic [15:0] SD1 = 16'h1234;
   localparam logic [15:0] SD2 = 16'h5678;

   initial begin
      int nSat;
      int expStalls;

      reset = 1'b1;
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      busA.rf_data1   = RF1;
      busA.rf_data2   = RF2;
      busA.stage_data = {SD2, SD1, SD0};
      busS.issue_valid = 1'b0; busS.rs1 = '0; busS.rs2 = '0; busS.rs1_used = 1'b0;
      busS.rs2_used = 1'b0; busS.rd = '0; busS.rd_we = 1'b0; busS.is_load = 1'b0;
      busS.flush = 1'b0; busS.rf_data1 = '0; busS.rf_data2 = '0; busS.stage_data = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      //    tag              iv r1   u1  r2   u2  rd   we  ld  fl  care opnd1 opnd2 s1 s2 stl cnt
      step("idle",          1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd0);
      step("add_r3",        1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd0);
      step("sub_fwd",       1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, SD0, RF2, 2'd1, 2'd0, 1'b0, 16'd0);
      step("ldr_r2",        1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd0);
      step("loaduse_stall", 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, RF1, RF2, 2'd0, 2'd0, 1'b1, 16'd0);
      step("loaduse_fwd",   1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, SD1, SD1, 2'd2, 2'd2, 1'b0, 16'd1);
      step("mov_r6a",       1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd1);
      step("nop1",          1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd1);
      step("mov_r6b",       1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd1);
      step("youngest_wins", 1'b1, 4'd6, 1'b1, 4'd4, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, SD0, RF2, 2'd1, 2'd0, 1'b0, 16'd1);
      step("ldr_r2b",       1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd1);
      step("flush_hazard",  1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd1);
      step("after_flush",   1'b1, 4'd4, 1'b1, 4'd2, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, RF1, SD1, 2'd0, 2'd2, 1'b0, 16'd1);
      step("we0_nomatch",   1'b1, 4'd8, 1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, RF1, SD2, 2'd0, 2'd3, 1'b0, 16'd1);
      step("alu_r10",       1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd1);
      step("nop2",          1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd1);
      step("ldr_r10",       1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b1, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd1);
      step("older_ignored", 1'b1, 4'd10, 1'b1, 4'd10, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b0, RF1, RF2, 2'd0, 2'd0, 1'b1, 16'd1);
      step("older_resolved",1'b1, 4'd10, 1'b1, 4'd10, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0, 1'b1, SD1, RF2, 2'd2, 2'd0, 1'b0, 16'd2);
      for (int i = 0; i < 3; i++) begin
         step("idle_retire",1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd2);
      end
      step("retired",       1'b1, 4'd10, 1'b1, 4'd10, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd2);
      step("ldr_r5",        1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd2);

      // Reset lands in the middle of a load-use stall.
      drive(1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
      expectOut("pre_reset", 1'b0, RF1, RF2, 2'd0, 2'd0, 1'b1, 16'd2);
      #1;
      compareHead();
      reset = 1'b1;
      expectOut("reset_mid_stall", 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd0);
      @(negedge clk);
      compareHead();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step("after_reset",   1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, RF1, RF2, 2'd0, 2'd0, 1'b0, 16'd0);
      step("alu_after_rst", 1'b1, 4'd4, 1'b1, 4'd1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, SD0, RF2, 2'd1, 2'd0, 1'b0, 16'd0);
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

      // Self-dependent load every issue: 31 stall cycles per 32 on the deep instance.
      busS.issue_valid = 1'b1;
      busS.rs1         = 4'd1;
      busS.rs1_used    = 1'b1;
      busS.rd          = 4'd1;
      busS.rd_we       = 1'b1;
      busS.is_load     = 1'b1;
      nSat = 67700;
      for (int cyc = 0; cyc < nSat; cyc++) begin
         @(negedge clk);
         if (cyc == 0) cmp("sat.first_issue_stall", {31'd0, busS.stall}, 32'd0);
         if (cyc == 1) cmp("sat.stall_start", {31'd0, busS.stall}, 32'd1);
         if (cyc == 32) begin
            cmp("sat.count_after_31", {16'd0, busS.stall_count}, 32'd31);
            cmp("sat.reissue_sel", {26'd0, busS.fwd_sel1}, 32'd32);
            cmp("sat.reissue_stall", {31'd0, busS.stall}, 32'd0);
         end
         @(posedge clk);
         #1;
      end
      expStalls = nSat - (nSat + 31) / 32;
      if (expStalls > 65535) expStalls = 65535;
      @(negedge clk);
      cmp("sat.count_saturated", {16'd0, busS.stall_count}, expStalls);
      busS.issue_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
